// File: rtl/regfile_wr_if.sv
// Writeback bus between the two requesters and the register-file write arbiter.
// The master side drives requests; the slave side returns grants and the write port.
interface regfile_wr_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_sel;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  wr_en, wr_addr, wr_data, wr_sel
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output wr_en, wr_addr, wr_data, wr_sel
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (rd)
// and load (rt) writeback paths, with a registered write port and contention counter.
module regfile_wr_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   regfile_wr_if.slave      bus,
   output logic [CNT_W-1:0] contend_cnt
);

   logic              grant0;
   logic              grant1;
   logic              contend;

   logic              wr_en_q,      wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,    wr_data_d;
   logic              wr_sel_q,     wr_sel_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;

   // Grants are suppressed during reset so pending requests never slip through.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset && !stall) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign contend = !reset && !stall && bus.req0_valid && bus.req1_valid;

   always_comb begin
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_sel_d     = wr_sel_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      // Register $0 is hardwired: the handshake completes but the write is masked.
      if (grant0) begin
         wr_en_d      = |bus.req0_addr;
         wr_addr_d    = bus.req0_addr;
         wr_data_d    = bus.req0_data;
         wr_sel_d     = 1'b0;
         last_grant_d = 1'b0;
      end else if (grant1) begin
         wr_en_d      = |bus.req1_addr;
         wr_addr_d    = bus.req1_addr;
         wr_data_d    = bus.req1_data;
         wr_sel_d     = 1'b1;
         last_grant_d = 1'b1;
      end
      if (contend && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
      if (reset) begin
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_sel_q     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_sel_q     <= wr_sel_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.wr_sel     = wr_sel_q;
   assign contend_cnt    = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a behavioural model predicts grants, and
// expected write-port values are queued per transfer and popped one cycle later.
module tb_regfile_wr_arbiter;

   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        sel;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall;
   logic [7:0] contend_cnt;
   logic [1:0] contend_cnt2;

   regfile_wr_if #(.DATA_W(32), .ADDR_W(5)) bus ();
   regfile_wr_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

   regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .bus         (bus.slave),
      .contend_cnt (contend_cnt)
   );

   // Narrow-counter instance sees identical stimulus to exercise saturation.
   regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .bus         (bus2.slave),
      .contend_cnt (contend_cnt2)
   );

   assign bus2.req0_valid = bus.req0_valid;
   assign bus2.req0_addr  = bus.req0_addr;
   assign bus2.req0_data  = bus.req0_data;
   assign bus2.req1_valid = bus.req1_valid;
   assign bus2.req1_addr  = bus.req1_addr;
   assign bus2.req1_data  = bus.req1_data;

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   wr_t  sb[$];
   wr_t  m_wr;
   logic m_last;
   int   m_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive0(input logic [4:0] a, input logic [31:0] d);
      bus.req0_valid = 1'b1;
      bus.req0_addr  = a;
      bus.req0_data  = d;
   endtask

   task automatic drive1(input logic [4:0] a, input logic [31:0] d);
      bus.req1_valid = 1'b1;
      bus.req1_addr  = a;
      bus.req1_data  = d;
   endtask

   // One clock: check outputs at the falling edge, advance the model, then let
   // any granted requester drop valid just after the rising edge.
   task automatic cycle(input string tag);
      logic g0, g1;
      if (sb.size() > 0) m_wr = sb.pop_front();
      else               m_wr.en = 1'b0;
      @(negedge clk);
      check({tag, ".wr_en"},   64'(bus.wr_en),   64'(m_wr.en));
      check({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'(m_wr.addr));
      check({tag, ".wr_data"}, 64'(bus.wr_data), 64'(m_wr.data));
      check({tag, ".wr_sel"},  64'(bus.wr_sel),  64'(m_wr.sel));
      check({tag, ".cnt"},     64'(contend_cnt),  64'((m_cnt > 255) ? 255 : m_cnt));
      check({tag, ".cnt2"},    64'(contend_cnt2), 64'((m_cnt > 3) ? 3 : m_cnt));

      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset && !stall) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (m_last) g0 = 1'b1;
            else        g1 = 1'b1;
         end else begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
         end
      end
      check({tag, ".ready0"}, 64'(bus.req0_ready), 64'(g0));
      check({tag, ".ready1"}, 64'(bus.req1_ready), 64'(g1));

      if (reset) begin
         sb.delete();
         sb.push_back('0);
         m_last = 1'b1;
         m_cnt  = 0;
      end else begin
         if (g0) begin
            sb.push_back('{en: (bus.req0_addr != 5'd0), addr: bus.req0_addr,
                           data: bus.req0_data, sel: 1'b0});
            m_last = 1'b0;
         end else if (g1) begin
            sb.push_back('{en: (bus.req1_addr != 5'd0), addr: bus.req1_addr,
                           data: bus.req1_data, sel: 1'b1});
            m_last = 1'b1;
         end
         if (bus.req0_valid && bus.req1_valid && !stall) m_cnt++;
      end

      @(posedge clk);
      #1;
      if (g0) bus.req0_valid = 1'b0;
      if (g1) bus.req1_valid = 1'b0;
   endtask

   initial begin
      m_wr   = '0;
      m_last = 1'b1;
      m_cnt  = 0;
      stall  = 1'b0;
      reset  = 1'b1;
      drive0(5'd3, 32'h1111_0000);
      drive1(5'd4, 32'h2222_0000);
      @(posedge clk);
      #1;

      // Reset held two cycles with both requesters valid.
      cycle("reset_a");
      cycle("reset_b");
      reset = 1'b0;

      // First tie after reset: requester 0, then requester 1.
      cycle("tie_0");
      cycle("tie_1");
      cycle("tie_drain");
      check("tie.cnt_one", 64'(contend_cnt), 64'd1);

      // Single requester.
      drive0(5'd8, 32'hDEAD_BEEF);
      cycle("single");
      cycle("single_out");
      check("single.data_literal", 64'(bus.wr_data), 64'hDEAD_BEEF);

      // Register $0 write from requester 1.
      drive1(5'd0, 32'd5);
      cycle("zero");
      cycle("zero_out");

      // Stall holds off the grant for three cycles.
      stall = 1'b1;
      drive0(5'd9, 32'h0000_1234);
      cycle("stall_0");
      cycle("stall_1");
      cycle("stall_2");
      stall = 1'b0;
      cycle("stall_release");
      cycle("stall_out");

      // Same address from both: winner in N+1, loser in N+2.
      drive0(5'd7, 32'd1);
      drive1(5'd7, 32'd2);
      cycle("same_a");
      cycle("same_b");
      cycle("same_out");

      // Both held valid for ten cycles; the 2-bit counter saturates at 3.
      for (int i = 0; i < 10; i++) begin
         if (!bus.req0_valid) drive0(5'(10 + i), 32'(32'hA000 + i));
         if (!bus.req1_valid) drive1(5'(20 + i), 32'(32'hB000 + i));
         cycle("sat");
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      cycle("sat_drain");
      check("sat.cnt2_max", 64'(contend_cnt2), 64'd3);

      // Reset arriving while a write is in flight.
      drive0(5'd12, 32'hCAFE_F00D);
      cycle("mid_xfer");
      reset = 1'b1;
      drive1(5'd13, 32'h0BAD_0BAD);
      cycle("mid_reset");
      reset = 1'b0;
      bus.req1_valid = 1'b0;
      cycle("mid_after");
      cycle("mid_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
